rv32i_decoder: RTL and testbench
================================

RV32I_DECODER -- requirements
Module: rv32i_decoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: instr is valid this cycle.
REQ-004 The block SHALL have port instr, input, 32 bits: RV32I instruction word.
REQ-005 The block SHALL have port out_valid, output, 1 bit: decoded outputs are valid.
REQ-006 The block SHALL have port op, output, 7 bits: opcode, equal to instr[6:0].
REQ-007 The block SHALL have ports rs1, rs2 and rd, outputs, 5 bits each: register indices.
REQ-008 The block SHALL have port func, output, 10 bits: {funct7, funct3} function code.
REQ-009 The block SHALL have port imm, output, 32 bits: immediate, sign-extended where the format requires.
REQ-010 The block SHALL have port illegal, output, 1 bit: the instruction is not supported.

Function
REQ-011 The block SHALL register all outputs with 1-cycle latency: when in_valid=1 at edge N, the decode of instr is presented after edge N with out_valid=1.
REQ-012 When in_valid=0 at an edge, out_valid SHALL be 0 and the data outputs SHALL hold their previous values.
REQ-013 The supported opcodes SHALL be: R=0110011, I=0010011, ILD=0000011, IJR=1100111, S=0100011, B=1100011, U(LUI)=0110111, AUIPC=0010111, J=1101111.
REQ-014 R-type: rs1, rs2 and rd SHALL be taken from the instruction; func={instr[31:25], instr[14:12]}; imm=0.
REQ-015 I-type: rs1 and rd SHALL be taken from the instruction; rs2=0; imm=sext(instr[31:20]); func={instr[31:25], funct3} for SLLI/SRLI/SRAI (funct3 001/101), otherwise {7'b0, funct3}.
REQ-016 ILD and IJR: rs1 and rd SHALL be taken from the instruction; rs2=0; func={7'b0, funct3}; imm=sext(instr[31:20]).
REQ-017 S-type: rs1 and rs2 SHALL be taken from the instruction; rd=0; func={7'b0, funct3}; imm=sext({instr[31:25], instr[11:7]}).
REQ-018 B-type: rs1 and rs2 SHALL be taken from the instruction; rd=0; func={7'b0, funct3}; imm=sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-019 U and AUIPC: rd SHALL be taken from the instruction; rs1=rs2=0; func=0; imm={instr[31:12], 12'b0}.
REQ-020 J-type: rd SHALL be taken from the instruction; rs1=rs2=0; func=0; imm=sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-021 illegal SHALL be 1 when any of the following holds:
- instr[1:0]!=11, or the opcode is unsupported;
- R-type: funct7 is not 0000000 or 0100000, or funct7=0100000 with funct3 not 000/101;
- SLLI: funct7!=0;
- SRLI/SRAI: funct7 is not 0000000 or 0100000;
- B: funct3 is 010 or 011;
- S: funct3>010;
- ILD: funct3 is 011, 110 or 111;
- IJR: funct3!=000.
REQ-022 On illegal=1, op SHALL still equal instr[6:0], all of rs1, rs2, rd, func and imm SHALL be 0, and out_valid SHALL follow REQ-011.

Reset
REQ-023 While rst=1 at an edge, out_valid, illegal, op, rs1, rs2, rd, func and imm SHALL all be 0 after that edge; rst SHALL take priority over in_valid.
REQ-024 An instruction accepted in the same cycle that rst=1 SHALL be discarded; the first valid output after reset SHALL come 1 cycle after the first in_valid with rst=0.

Structure
REQ-025 Package rv32i_pkg SHALL hold the opcode constants (INSTR_TYP_R, _I, _ILD, _IJR, _S, _B, _U, _AUIPC, _J) and the 10-bit func codes (R_TYP_FC_*, I_TYP_FC_*, ILD_TYP_FC_*, IJR_TYP_FC_JALR, S_TYP_FC_*, B_TYP_FC_*).
REQ-026 The immediate extraction SHALL be one combinational sub-module, rv32i_imm_gen, that takes instr and returns imm; decoding and the output register SHALL be in rv32i_decoder.

Verification
REQ-027 The bench SHALL check add x3,x1,x2 (0x002081B3): op=0110011, rs1=1, rs2=2, rd=3, func=0, imm=0, illegal=0; and sub (0x402081B3): func=0100000000.
REQ-028 The bench SHALL check addi x1,x0,-1 (0xFFF00093): rs1=0, rd=1, rs2=0, imm=0xFFFFFFFF, func=0.
REQ-029 The bench SHALL check sw x2,8(x1) (0x0020A423): rs1=1, rs2=2, rd=0, func=0000000010, imm=8.
REQ-030 The bench SHALL check beq x1,x2,-4 (0xFE208EE3): imm=0xFFFFFFFC, func=0; and lui x5,0x12345 (0x123452B7): rd=5, imm=0x12345000.
REQ-031 The bench SHALL check 0x00000000: illegal=1, op=0, all other data outputs 0, out_valid=1 one cycle later.
REQ-032 The bench SHALL check back-to-back in_valid with rst pulsed mid-stream: after the reset edge all outputs are 0; the next instruction appears exactly 1 cycle after it is accepted.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: major opcodes and 10-bit {funct7, funct3} codes
// for the supported instruction classes.
package rv32i_pkg;

    localparam logic [6:0] INSTR_TYP_R     = 7'b0110011;
    localparam logic [6:0] INSTR_TYP_I     = 7'b0010011;
    localparam logic [6:0] INSTR_TYP_ILD   = 7'b0000011;
    localparam logic [6:0] INSTR_TYP_IJR   = 7'b1100111;
    localparam logic [6:0] INSTR_TYP_S     = 7'b0100011;
    localparam logic [6:0] INSTR_TYP_B     = 7'b1100011;
    localparam logic [6:0] INSTR_TYP_U     = 7'b0110111;
    localparam logic [6:0] INSTR_TYP_AUIPC = 7'b0010111;
    localparam logic [6:0] INSTR_TYP_J     = 7'b1101111;

    localparam logic [9:0] R_TYP_FC_ADD  = 10'b0000000_000;
    localparam logic [9:0] R_TYP_FC_SUB  = 10'b0100000_000;
    localparam logic [9:0] R_TYP_FC_SLL  = 10'b0000000_001;
    localparam logic [9:0] R_TYP_FC_SLT  = 10'b0000000_010;
    localparam logic [9:0] R_TYP_FC_SLTU = 10'b0000000_011;
    localparam logic [9:0] R_TYP_FC_XOR  = 10'b0000000_100;
    localparam logic [9:0] R_TYP_FC_SRL  = 10'b0000000_101;
    localparam logic [9:0] R_TYP_FC_SRA  = 10'b0100000_101;
    localparam logic [9:0] R_TYP_FC_OR   = 10'b0000000_110;
    localparam logic [9:0] R_TYP_FC_AND  = 10'b0000000_111;

    localparam logic [9:0] I_TYP_FC_ADDI  = 10'b0000000_000;
    localparam logic [9:0] I_TYP_FC_SLLI  = 10'b0000000_001;
    localparam logic [9:0] I_TYP_FC_SLTI  = 10'b0000000_010;
    localparam logic [9:0] I_TYP_FC_SLTIU = 10'b0000000_011;
    localparam logic [9:0] I_TYP_FC_XORI  = 10'b0000000_100;
    localparam logic [9:0] I_TYP_FC_SRLI  = 10'b0000000_101;
    localparam logic [9:0] I_TYP_FC_SRAI  = 10'b0100000_101;
    localparam logic [9:0] I_TYP_FC_ORI   = 10'b0000000_110;
    localparam logic [9:0] I_TYP_FC_ANDI  = 10'b0000000_111;

    localparam logic [9:0] ILD_TYP_FC_LB  = 10'b0000000_000;
    localparam logic [9:0] ILD_TYP_FC_LH  = 10'b0000000_001;
    localparam logic [9:0] ILD_TYP_FC_LW  = 10'b0000000_010;
    localparam logic [9:0] ILD_TYP_FC_LBU = 10'b0000000_100;
    localparam logic [9:0] ILD_TYP_FC_LHU = 10'b0000000_101;

    localparam logic [9:0] IJR_TYP_FC_JALR = 10'b0000000_000;

    localparam logic [9:0] S_TYP_FC_SB = 10'b0000000_000;
    localparam logic [9:0] S_TYP_FC_SH = 10'b0000000_001;
    localparam logic [9:0] S_TYP_FC_SW = 10'b0000000_010;

    localparam logic [9:0] B_TYP_FC_BEQ  = 10'b0000000_000;
    localparam logic [9:0] B_TYP_FC_BNE  = 10'b0000000_001;
    localparam logic [9:0] B_TYP_FC_BLT  = 10'b0000000_100;
    localparam logic [9:0] B_TYP_FC_BGE  = 10'b0000000_101;
    localparam logic [9:0] B_TYP_FC_BLTU = 10'b0000000_110;
    localparam logic [9:0] B_TYP_FC_BGEU = 10'b0000000_111;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate extraction: selects the format-specific bit scatter
// from the opcode and sign-extends where the format calls for it.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            INSTR_TYP_I, INSTR_TYP_ILD, INSTR_TYP_IJR:
                imm = {{20{instr[31]}}, instr[31:20]};
            INSTR_TYP_S:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            INSTR_TYP_B:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            INSTR_TYP_U, INSTR_TYP_AUIPC:
                imm = {instr[31:12], 12'd0};
            INSTR_TYP_J:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_decoder.sv
// RV32I instruction decoder: field extraction, legality check and a single
// output register stage (one cycle from accepted instruction to valid output).
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        out_valid,
    output logic [6:0]  op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [9:0]  func,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [31:0] imm_raw;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [9:0]  func_full;
    logic        dec_illegal;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [9:0]  dec_func;

    logic        out_valid_d, out_valid_q;
    logic        illegal_d, illegal_q;
    logic [6:0]  op_d, op_q;
    logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [9:0]  func_d, func_q;
    logic [31:0] imm_d, imm_q;

    rv32i_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm_raw)
    );

    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign func_full = {funct7, funct3};

    // Legality is judged on the full {funct7, funct3} against the package codes.
    always_comb begin
        dec_illegal = 1'b0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        dec_rd      = 5'd0;
        dec_func    = 10'd0;
        case (instr[6:0])
            INSTR_TYP_R: begin
                dec_rs1     = instr[19:15];
                dec_rs2     = instr[24:20];
                dec_rd      = instr[11:7];
                dec_func    = func_full;
                dec_illegal = !(func_full inside {R_TYP_FC_ADD, R_TYP_FC_SUB, R_TYP_FC_SLL,
                                                  R_TYP_FC_SLT, R_TYP_FC_SLTU, R_TYP_FC_XOR,
                                                  R_TYP_FC_SRL, R_TYP_FC_SRA, R_TYP_FC_OR,
                                                  R_TYP_FC_AND});
            end
            INSTR_TYP_I: begin
                dec_rs1 = instr[19:15];
                dec_rd  = instr[11:7];
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_func    = func_full;
                    dec_illegal = !(func_full inside {I_TYP_FC_SLLI, I_TYP_FC_SRLI, I_TYP_FC_SRAI});
                end else begin
                    dec_func = {7'd0, funct3};
                end
            end
            INSTR_TYP_ILD: begin
                dec_rs1     = instr[19:15];
                dec_rd      = instr[11:7];
                dec_func    = {7'd0, funct3};
                dec_illegal = !({7'd0, funct3} inside {ILD_TYP_FC_LB, ILD_TYP_FC_LH, ILD_TYP_FC_LW,
                                                       ILD_TYP_FC_LBU, ILD_TYP_FC_LHU});
            end
            INSTR_TYP_IJR: begin
                dec_rs1     = instr[19:15];
                dec_rd      = instr[11:7];
                dec_func    = {7'd0, funct3};
                dec_illegal = ({7'd0, funct3} != IJR_TYP_FC_JALR);
            end
            INSTR_TYP_S: begin
                dec_rs1     = instr[19:15];
                dec_rs2     = instr[24:20];
                dec_func    = {7'd0, funct3};
                dec_illegal = !({7'd0, funct3} inside {S_TYP_FC_SB, S_TYP_FC_SH, S_TYP_FC_SW});
            end
            INSTR_TYP_B: begin
                dec_rs1     = instr[19:15];
                dec_rs2     = instr[24:20];
                dec_func    = {7'd0, funct3};
                dec_illegal = !({7'd0, funct3} inside {B_TYP_FC_BEQ, B_TYP_FC_BNE, B_TYP_FC_BLT,
                                                       B_TYP_FC_BGE, B_TYP_FC_BLTU, B_TYP_FC_BGEU});
            end
            INSTR_TYP_U, INSTR_TYP_AUIPC, INSTR_TYP_J: begin
                dec_rd = instr[11:7];
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
    end

    // Data outputs hold when no instruction is accepted; an illegal decode keeps only op.
    always_comb begin
        out_valid_d = 1'b0;
        illegal_d   = illegal_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        func_d      = func_q;
        imm_d       = imm_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
            illegal_d   = dec_illegal;
            op_d        = instr[6:0];
            rs1_d       = dec_illegal ? 5'd0  : dec_rs1;
            rs2_d       = dec_illegal ? 5'd0  : dec_rs2;
            rd_d        = dec_illegal ? 5'd0  : dec_rd;
            func_d      = dec_illegal ? 10'd0 : dec_func;
            imm_d       = dec_illegal ? 32'd0 : imm_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= 7'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            func_q      <= 10'd0;
            imm_q       <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            func_q      <= func_d;
            imm_q       <= imm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign op        = op_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign func      = func_q;
    assign imm       = imm_q;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Directed self-checking bench for rv32i_decoder with hand-computed expected
// decodes for each instruction class, illegal encodings and mid-stream reset.
module tb_rv32i_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_valid;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  func;
    logic [31:0] imm;
    logic        illegal;

    int testCount = 0;
    int failCount = 0;

    rv32i_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .instr     (instr),
        .out_valid (out_valid),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .imm       (imm),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] word);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        instr    = word;
        @(posedge clk);
        #1;
    endtask

    task automatic checkDecode(input string tag, input logic ov, input logic ill, input logic [6:0] e_op,
                               input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                               input logic [9:0] e_func, input logic [31:0] e_imm);
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        checkOutput({tag, ".illegal"},   {31'd0, illegal},   {31'd0, ill});
        checkOutput({tag, ".op"},        {25'd0, op},        {25'd0, e_op});
        checkOutput({tag, ".rs1"},       {27'd0, rs1},       {27'd0, e_rs1});
        checkOutput({tag, ".rs2"},       {27'd0, rs2},       {27'd0, e_rs2});
        checkOutput({tag, ".rd"},        {27'd0, rd},        {27'd0, e_rd});
        checkOutput({tag, ".func"},      {22'd0, func},      {22'd0, e_func});
        checkOutput({tag, ".imm"},       imm,                e_imm);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        instr    = 32'd0;

        // Reset with a valid instruction present: it must be discarded.
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h002081B3);
        checkDecode("reset", 1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 10'd0, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h002081B3);
        checkDecode("add", 1'b1, 1'b0, 7'b0110011, 5'd1, 5'd2, 5'd3, 10'd0, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h402081B3);
        checkDecode("sub", 1'b1, 1'b0, 7'b0110011, 5'd1, 5'd2, 5'd3, 10'b0100000000, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'hFFF00093);
        checkDecode("addi", 1'b1, 1'b0, 7'b0010011, 5'd0, 5'd0, 5'd1, 10'd0, 32'hFFFFFFFF);

        applyStimulus(1'b0, 1'b1, 32'h40315093);
        checkDecode("srai", 1'b1, 1'b0, 7'b0010011, 5'd2, 5'd0, 5'd1, 10'b0100000101, 32'h00000403);

        applyStimulus(1'b0, 1'b1, 32'h40311093);
        checkDecode("slli_bad", 1'b1, 1'b1, 7'b0010011, 5'd0, 5'd0, 5'd0, 10'd0, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h0020A423);
        checkDecode("sw", 1'b1, 1'b0, 7'b0100011, 5'd1, 5'd2, 5'd0, 10'b0000000010, 32'd8);

        applyStimulus(1'b0, 1'b1, 32'hFE208EE3);
        checkDecode("beq", 1'b1, 1'b0, 7'b1100011, 5'd1, 5'd2, 5'd0, 10'd0, 32'hFFFFFFFC);

        applyStimulus(1'b0, 1'b1, 32'h008000EF);
        checkDecode("jal", 1'b1, 1'b0, 7'b1101111, 5'd0, 5'd0, 5'd1, 10'd0, 32'd8);

        applyStimulus(1'b0, 1'b1, 32'h123452B7);
        checkDecode("lui", 1'b1, 1'b0, 7'b0110111, 5'd0, 5'd0, 5'd5, 10'd0, 32'h12345000);

        // No instruction accepted: out_valid drops, data holds the lui decode.
        applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF);
        checkDecode("hold", 1'b0, 1'b0, 7'b0110111, 5'd0, 5'd0, 5'd5, 10'd0, 32'h12345000);

        applyStimulus(1'b0, 1'b1, 32'h00000000);
        checkDecode("zero_word", 1'b1, 1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 10'd0, 32'd0);

        // Back-to-back stream with a reset pulse in the middle.
        applyStimulus(1'b0, 1'b1, 32'h002081B3);
        checkDecode("b2b_add", 1'b1, 1'b0, 7'b0110011, 5'd1, 5'd2, 5'd3, 10'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h402081B3);
        checkDecode("b2b_rst", 1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 10'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hFFF00093);
        checkDecode("b2b_addi", 1'b1, 1'b0, 7'b0010011, 5'd0, 5'd0, 5'd1, 10'd0, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("b2b_idle.out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
